// File: rtl/recur_sched_if.sv
// Scheduler-side bundle: host start/status, frame RAM ports,
// stage enables, executing-frame view and write-back results.
interface recur_sched_if #(
    parameter int ADDR_W = 12
);
    localparam int SW = ADDR_W + 6;

    logic              start;
    logic [31:0]       root_izkl;
    logic              busy;
    logic              done;
    logic              err_ovf;
    logic [ADDR_W:0]   max_sp;

    logic [ADDR_W-1:0] st_addr;
    logic              st_we;
    logic [SW-1:0]     st_wdata;
    logic [SW-1:0]     st_rdata;
    logic [ADDR_W-1:0] ix_addr;
    logic              ix_we;
    logic [31:0]       ix_wdata;
    logic [31:0]       ix_rdata;

    logic [2:0]        en_stage;
    logic [ADDR_W-1:0] cur_addr;
    logic [SW-1:0]     cur_state;
    logic [31:0]       cur_izkl;

    logic              wb_done;
    logic              wb_pos_en;
    logic [4:0]        wb_pos;
    logic              wb_push;
    logic [31:0]       wb_push_izkl;

    modport master (
        input  start, root_izkl, st_rdata, ix_rdata,
        input  wb_done, wb_pos_en, wb_pos, wb_push, wb_push_izkl,
        output busy, done, err_ovf, max_sp,
        output st_addr, st_we, st_wdata, ix_addr, ix_we, ix_wdata,
        output en_stage, cur_addr, cur_state, cur_izkl
    );

    modport slave (
        output start, root_izkl, st_rdata, ix_rdata,
        output wb_done, wb_pos_en, wb_pos, wb_push, wb_push_izkl,
        input  busy, done, err_ovf, max_sp,
        input  st_addr, st_we, st_wdata, ix_addr, ix_we, ix_wdata,
        input  en_stage, cur_addr, cur_state, cur_izkl
    );
endinterface

// File: rtl/recur_sched.sv
// Frame-stack scheduler for the inexact-recursion engine.
// Ports: clk, rst_n (sync, active-low), bus (recur_sched_if.master).
module recur_sched #(
    parameter int                ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] ROOT_PARENT = '1
) (
    input logic           clk,
    input logic           rst_n,
    recur_sched_if.master bus
);
    localparam int              SW      = ADDR_W + 6;
    localparam int              SP_W    = ADDR_W + 1;
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(1 << ADDR_W);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    typedef enum logic [3:0] {
        IDLE, INIT, FETCH_RD, FETCH_CHK,
        S1, S2, S3, WR1, WR2, DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [SP_W-1:0]   r_sp;
    logic [SP_W-1:0]   r_max_sp;
    logic              r_err_ovf;
    logic [31:0]       r_root;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [SW-1:0]     r_cur_state;
    logic [31:0]       r_cur_izkl;
    logic              r_wb_done;
    logic              r_wb_pos_en;
    logic [4:0]        r_wb_pos;
    logic              r_wb_push;
    logic [31:0]       r_wb_izkl;

    logic [ADDR_W-1:0] w_top;
    logic [SP_W-1:0]   w_sp_inc;
    logic              w_full;

    assign w_top    = r_sp[ADDR_W-1:0] - A_ONE;
    assign w_sp_inc = r_sp + SP_ONE;
    assign w_full   = (r_sp == SP_FULL);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sp        <= '0;
            r_max_sp    <= '0;
            r_err_ovf   <= 1'b0;
            r_root      <= '0;
            r_cur_addr  <= '0;
            r_cur_state <= '0;
            r_cur_izkl  <= '0;
            r_wb_done   <= 1'b0;
            r_wb_pos_en <= 1'b0;
            r_wb_pos    <= '0;
            r_wb_push   <= 1'b0;
            r_wb_izkl   <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_err_ovf <= 1'b0;
                    r_max_sp  <= '0;
                    r_root    <= bus.root_izkl;
                end
                INIT: begin
                    r_sp     <= SP_ONE;
                    r_max_sp <= SP_ONE;
                end
                FETCH_CHK: begin
                    r_cur_addr  <= w_top;
                    r_cur_state <= bus.st_rdata;
                    r_cur_izkl  <= bus.ix_rdata;
                    if (bus.st_rdata[0]) r_sp <= r_sp - SP_ONE;
                end
                S3: begin
                    r_wb_done   <= bus.wb_done;
                    r_wb_pos_en <= bus.wb_pos_en;
                    r_wb_pos    <= bus.wb_pos;
                    r_wb_push   <= bus.wb_push;
                    r_wb_izkl   <= bus.wb_push_izkl;
                end
                WR1: if (r_wb_push && w_full) r_err_ovf <= 1'b1;
                WR2: begin
                    r_sp <= w_sp_inc;
                    if (w_sp_inc > r_max_sp) r_max_sp <= w_sp_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (bus.start) w_next = INIT;
            INIT:      w_next = FETCH_RD;
            FETCH_RD:  w_next = FETCH_CHK;
            FETCH_CHK: begin
                if (!bus.st_rdata[0])  w_next = S1;
                else if (r_sp == SP_ONE) w_next = DONE;
                else                   w_next = FETCH_RD;
            end
            S1:        w_next = S2;
            S2:        w_next = S3;
            S3:        w_next = WR1;
            WR1: begin
                if (!r_wb_push) w_next = FETCH_RD;
                else if (w_full) w_next = DONE;
                else            w_next = WR2;
            end
            WR2:       w_next = FETCH_RD;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (r_state != IDLE) && (r_state != DONE);
        bus.done     = (r_state == DONE);
        bus.st_addr  = '0;
        bus.st_we    = 1'b0;
        bus.st_wdata = '0;
        bus.ix_addr  = '0;
        bus.ix_we    = 1'b0;
        bus.ix_wdata = '0;
        bus.en_stage = 3'b000;
        case (r_state)
            INIT: begin
                bus.st_we    = 1'b1;
                bus.st_wdata = {5'd0, ROOT_PARENT, 1'b0};
                bus.ix_we    = 1'b1;
                bus.ix_wdata = r_root;
            end
            FETCH_RD, FETCH_CHK: begin
                bus.st_addr = w_top;
                bus.ix_addr = w_top;
            end
            S1: bus.en_stage = 3'b001;
            S2: bus.en_stage = 3'b010;
            S3: bus.en_stage = 3'b100;
            WR1: begin
                // Merge: new pos wins, done bit only ever sets.
                bus.st_addr  = r_cur_addr;
                bus.st_we    = r_wb_done | r_wb_pos_en;
                bus.st_wdata = {
                    r_wb_pos_en ? r_wb_pos : r_cur_state[SW-1 -: 5],
                    r_cur_state[ADDR_W:1],
                    r_wb_done | r_cur_state[0]
                };
                bus.ix_addr  = r_sp[ADDR_W-1:0];
                bus.ix_we    = r_wb_push & ~w_full;
                bus.ix_wdata = r_wb_izkl;
            end
            WR2: begin
                bus.st_addr  = r_sp[ADDR_W-1:0];
                bus.st_we    = 1'b1;
                bus.st_wdata = {5'd0, r_cur_addr, 1'b0};
            end
            default: ;
        endcase
    end

    assign bus.err_ovf   = r_err_ovf;
    assign bus.max_sp    = r_max_sp;
    assign bus.cur_addr  = r_cur_addr;
    assign bus.cur_state = r_cur_state;
    assign bus.cur_izkl  = r_cur_izkl;
endmodule

// File: tb/tb_recur_sched.sv
// Bench for recur_sched: RAM models plus a frame-stack reference.
// Small ADDR_W so the overflow path is reachable.
`timescale 1ns/1ps
module tb_recur_sched;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int SW     = ADDR_W + 6;
    localparam logic [ADDR_W-1:0] RP = '1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    recur_sched_if #(.ADDR_W(ADDR_W)) u_if ();
    recur_sched #(.ADDR_W(ADDR_W), .ROOT_PARENT(RP)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(u_if)
    );

    logic [SW-1:0] r_st_mem [DEPTH];
    logic [31:0]   r_ix_mem [DEPTH];
    always @(posedge clk) begin
        if (u_if.st_we) r_st_mem[u_if.st_addr] <= u_if.st_wdata;
        if (u_if.ix_we) r_ix_mem[u_if.ix_addr] <= u_if.ix_wdata;
        u_if.st_rdata <= r_st_mem[u_if.st_addr];
        u_if.ix_rdata <= r_ix_mem[u_if.ix_addr];
    end

    // Reference: expected RAM image and stack depth.
    logic [SW-1:0] m_st [DEPTH];
    logic [31:0]   m_ix [DEPTH];
    bit            m_wst [DEPTH];
    bit            m_wix [DEPTH];
    int            m_sp;
    int            m_max;
    bit            m_ovf;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic junk(input bit poke);
        u_if.wb_done      = 1'($urandom);
        u_if.wb_pos_en    = 1'($urandom);
        u_if.wb_pos       = 5'($urandom);
        u_if.wb_push      = 1'($urandom);
        u_if.wb_push_izkl = $urandom;
        u_if.start        = poke ? 1'($urandom) : 1'b0;
        if (poke) u_if.root_izkl = $urandom;
    endtask

    task automatic settle(output bit over);
        while (m_sp > 0 && m_st[m_sp-1][0]) m_sp--;
        over = (m_sp == 0) || m_ovf;
    endtask

    task automatic begin_search(input logic [31:0] root);
        u_if.start     = 1'b1;
        u_if.root_izkl = root;
        @(negedge clk);
        u_if.start = 1'b0;
        chk("busy_start", u_if.busy, 1);
        chk("ovf_clr", u_if.err_ovf, 0);
        repeat (3) @(negedge clk);
        chk("lat_s1", u_if.en_stage, 3'b001);
        m_st[0]  = {5'd0, RP, 1'b0};
        m_ix[0]  = root;
        m_wst[0] = 1'b1;
        m_wix[0] = 1'b1;
        m_sp     = 1;
        m_max    = 1;
        m_ovf    = 1'b0;
    endtask

    task automatic run_frame(input bit d, input bit pe, input logic [4:0] p,
                             input bit pu, input logic [31:0] iz,
                             input bit poke);
        int top;
        int n;
        logic [SW-1:0] w;
        n = 0;
        while (u_if.en_stage != 3'b001 && n < 20) begin
            junk(0);
            @(negedge clk);
            n++;
        end
        if (u_if.en_stage != 3'b001) begin
            chk("s1_timeout", u_if.en_stage, 3'b001);
            return;
        end
        top = m_sp - 1;
        chk("cur_addr", u_if.cur_addr, top);
        chk("cur_state", u_if.cur_state, m_st[top]);
        chk("cur_izkl", u_if.cur_izkl, m_ix[top]);
        junk(poke);
        @(negedge clk);
        chk("en_s2", u_if.en_stage, 3'b010);
        chk("busy_s2", u_if.busy, 1);
        junk(poke);
        @(negedge clk);
        chk("en_s3", u_if.en_stage, 3'b100);
        u_if.start        = 1'b0;
        u_if.wb_done      = d;
        u_if.wb_pos_en    = pe;
        u_if.wb_pos       = p;
        u_if.wb_push      = pu;
        u_if.wb_push_izkl = iz;
        @(negedge clk);
        junk(0);
        if (d || pe) begin
            w = m_st[top];
            if (pe) w[SW-1 -: 5] = p;
            if (d) w[0] = 1'b1;
            m_st[top]  = w;
            m_wst[top] = 1'b1;
        end
        if (pu) begin
            if (m_sp == DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                m_ix[m_sp]  = iz;
                m_st[m_sp]  = {5'd0, ADDR_W'(top), 1'b0};
                m_wix[m_sp] = 1'b1;
                m_wst[m_sp] = 1'b1;
                m_sp++;
                if (m_sp > m_max) m_max = m_sp;
            end
        end
    endtask

    task automatic end_search();
        int n;
        n = 0;
        while (!u_if.done && n < 20) begin
            junk(0);
            @(negedge clk);
            n++;
        end
        chk("done_pulse", u_if.done, 1);
        chk("busy_done", u_if.busy, 0);
        chk("err_ovf", u_if.err_ovf, m_ovf);
        chk("max_sp", u_if.max_sp, m_max);
        @(negedge clk);
        chk("done_1cyc", u_if.done, 0);
        chk("busy_idle", u_if.busy, 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (m_wst[i]) chk($sformatf("st_mem%0d", i), r_st_mem[i], m_st[i]);
            if (m_wix[i]) chk($sformatf("ix_mem%0d", i), r_ix_mem[i], m_ix[i]);
        end
    endtask

    task automatic rand_search();
        bit over;
        bit d;
        bit pu;
        int f;
        begin_search($urandom);
        f = 0;
        over = 1'b0;
        while (!over && f < 200) begin
            d  = (($urandom % 100) < 40) || (f > 30);
            pu = (f <= 30) && (($urandom % 100) < 35);
            run_frame(d, 1'($urandom), 5'($urandom), pu, $urandom,
                      ($urandom % 4) == 0);
            f++;
            settle(over);
        end
        end_search();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        bit over;
        for (int i = 0; i < DEPTH; i++) begin
            m_wst[i] = 1'b0;
            m_wix[i] = 1'b0;
        end
        u_if.start = 1'b0;
        u_if.root_izkl = '0;
        junk(0);
        repeat (3) @(negedge clk);
        chk("rst_busy", u_if.busy, 0);
        chk("rst_done", u_if.done, 0);
        chk("rst_en", u_if.en_stage, 0);
        chk("rst_ovf", u_if.err_ovf, 0);
        chk("rst_max", u_if.max_sp, 0);
        chk("rst_we", {u_if.st_we, u_if.ix_we}, 0);
        chk("rst_cur", {u_if.cur_addr, u_if.cur_state, u_if.cur_izkl}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        begin_search(32'h03010009);
        run_frame(1, 0, 0, 0, 0, 0);
        settle(over);
        end_search();

        begin_search(32'h03010009);
        run_frame(0, 1, 5, 1, 32'h02010305, 0);
        settle(over);
        run_frame(1, 0, 0, 0, 0, 0);
        settle(over);
        run_frame(1, 0, 0, 0, 0, 0);
        settle(over);
        end_search();

        begin_search($urandom);
        run_frame(1, 1, 7, 0, 0, 0);
        settle(over);
        end_search();
        chk("pos7_word", r_st_mem[0], {5'd7, RP, 1'b1});

        begin_search($urandom);
        for (int i = 0; i < 4; i++) begin
            run_frame(0, 0, 0, 1, $urandom, 0);
            settle(over);
        end
        end_search();

        @(negedge clk);
        chk("ovf_sticky", u_if.err_ovf, 1);
        begin_search($urandom);
        run_frame(0, 0, 0, 1, $urandom, 1);
        settle(over);
        run_frame(1, 0, 0, 0, 0, 1);
        settle(over);
        run_frame(1, 0, 0, 0, 0, 1);
        settle(over);
        end_search();

        begin_search($urandom);
        junk(0);
        @(negedge clk);
        chk("pre_rst_s2", u_if.en_stage, 3'b010);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_s2_en", u_if.en_stage, 0);
        chk("rst_s2_busy", u_if.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        repeat (40) rand_search();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
